uart_rx: RTL and testbench

UART receiver: recovers 8N1-style frames from the asynchronous serial line `rx` using an oversampling tick from a shared baud generator instance configured at BAUD*OVERSAMPLE.
- Presents each received byte on a valid/ready holding register.
- Flags framing errors and overruns.
- Sits between the pad and the UART controller's command/FIFO logic.
- Receive-side counterpart to the transmit path driven by the same tick source.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop synchronised line, mid-bit sampling, LSB-first frames,
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   deliver;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    deliver    = 1'b0;
    ferr_d     = 1'b0;
    if (os_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == TICK_MID) begin
            // Start bit must still be low at mid-bit, otherwise treat it as a glitch.
            if (!rx_s) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == TICK_END) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_cnt_q == TICK_END) begin
            if (rx_s) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A full register may still accept a new byte when it is being drained on the same edge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames driven bit-by-bit on the line; delivery timing predicted by
// counting oversampling ticks from the synchronised start edge, payloads checked against queues.
module tb_uart_rx;

  localparam int BIT_CLKS  = 64;   // 16 ticks per bit, one tick every 4 clocks
  localparam int STOP_TICK = 152;  // OVERSAMPLE/2 + 9*OVERSAMPLE

  logic       clk;
  logic       rst_n;
  logic       os_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_chk;
  int         n_pass;
  int         ferr_cnt;
  int         ovr_cnt;
  logic [7:0] got_q[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .os_tick  (os_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #2 os_tick = 1'b1;
      @(posedge clk);
      #2 os_tick = 1'b0;
    end
  end

  initial begin
    ferr_cnt = 0;
    ovr_cnt  = 0;
  end

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT_CLKS);
    end
    rx = stop_bit;
    step(BIT_CLKS);
  endtask

  // Drives a good frame and checks the holding register on the clocks either side of the
  // predicted stop-sample edge; optionally raises rx_ready for exactly that edge.
  task automatic send_timed(input string tag, input logic [7:0] d, input bit rdy,
                            input bit pre_v, input logic [7:0] pre_d, input logic [7:0] post_d);
    fork
      send_frame(d, 1'b1);
      begin
        repeat (2) @(posedge clk);
        do @(posedge clk); while (!os_tick);
        repeat (STOP_TICK - 1) begin
          do @(posedge clk); while (!os_tick);
        end
        repeat (3) @(posedge clk);
        #2;
        chk({tag, "_pre_valid"}, 32'(rx_valid), 32'(pre_v));
        if (pre_v) chk({tag, "_pre_data"}, 32'(rx_data), 32'(pre_d));
        if (rdy) rx_ready = 1'b1;
        @(posedge clk);
        #2;
        rx_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_post_data"}, 32'(rx_data), 32'(post_d));
      end
    join
  endtask

  task automatic consume(input string tag, input logic [7:0] exp);
    int n0;
    n0 = got_q.size();
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk({tag, "_cleared"}, 32'(rx_valid), 32'd0);
    chk({tag, "_held"}, 32'(rx_data), 32'(exp));
    chk({tag, "_taken"}, 32'(got_q.size()), 32'(n0 + 1));
  endtask

  initial begin
    int         f0;
    int         o0;
    int         g0;
    logic [7:0] exp_q[$];

    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    step(5);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    step(40);

    // Basic frame with latency check around the stop-sample edge.
    send_timed("t1", 8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5);
    chk("t1_ferr", 32'(ferr_cnt), 32'd0);
    consume("t1_rd", 8'hA5);

    // Short low glitch is rejected at the start-bit mid-point.
    step(20);
    f0 = ferr_cnt;
    rx = 1'b0;
    step(8);
    chk("t2_busy_in", 32'(busy), 32'd1);
    step(4);
    rx = 1'b1;
    step(40);
    chk("t2_busy_out", 32'(busy), 32'd0);
    chk("t2_valid", 32'(rx_valid), 32'd0);
    chk("t2_ferr", 32'(ferr_cnt), 32'(f0));

    // Bad stop bit followed by a held-low line, then recovery.
    step(20);
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    step(160);
    chk("t3_ferr_once", 32'(ferr_cnt), 32'(f0 + 1));
    chk("t3_valid", 32'(rx_valid), 32'd0);
    chk("t3_break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    step(BIT_CLKS);
    chk("t3_idle", 32'(busy), 32'd0);
    send_timed("t3b", 8'h55, 1'b0, 1'b0, 8'h00, 8'h55);
    consume("t3_rd", 8'h55);
    chk("t3_ferr_after", 32'(ferr_cnt), 32'(f0 + 1));

    // Overrun: second byte dropped while the first is still held.
    step(20);
    send_timed("t4a", 8'h11, 1'b0, 1'b0, 8'h00, 8'h11);
    o0 = ovr_cnt;
    step(16);
    send_timed("t4b", 8'h22, 1'b0, 1'b1, 8'h11, 8'h11);
    step(4);
    chk("t4_ovr_pulse", 32'(ovr_cnt), 32'(o0 + 1));
    // Same-edge drain and reload: no overrun, new byte replaces the old one.
    o0 = ovr_cnt;
    g0 = got_q.size();
    step(16);
    send_timed("t4c", 8'h22, 1'b1, 1'b1, 8'h11, 8'h22);
    step(4);
    chk("t4_no_ovr", 32'(ovr_cnt), 32'(o0));
    chk("t4_drained", 32'(got_q.size()), 32'(g0 + 1));
    if (got_q.size() > g0) chk("t4_drained_data", 32'(got_q[g0]), 32'h11);
    consume("t4_rd", 8'h22);

    // Reset in the middle of a frame.
    step(20);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        step(BIT_CLKS * 3 + 32);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("t5_rst_valid", 32'(rx_valid), 32'd0);
        chk("t5_rst_data", 32'(rx_data), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ferr", 32'(frame_err), 32'd0);
      end
    join
    step(16);
    rst_n = 1'b1;
    step(BIT_CLKS);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_no_partial", 32'(rx_valid), 32'd0);
    send_timed("t5", 8'h81, 1'b0, 1'b0, 8'h00, 8'h81);
    consume("t5_rd", 8'h81);

    // Back-to-back random bytes with the consumer always ready.
    step(40);
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    g0 = got_q.size();
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    step(20);
    rx_ready = 1'b0;
    chk("t6_count", 32'(got_q.size() - g0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (g0 + i < got_q.size()) chk($sformatf("t6_byte%0d", i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
      else chk($sformatf("t6_missing%0d", i), 32'd1, 32'd0);
    end
    chk("t6_ferr", 32'(ferr_cnt), 32'(f0));
    chk("t6_ovr", 32'(ovr_cnt), 32'(o0));
    chk("t6_valid_end", 32'(rx_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
